// File: rtl/updown_sweep_ctrl.sv
// Up/down sweep sequencer: owns the count register and bounces it between latched lo/hi limits.
// Optional endpoint dwell (HOLD_HI/HOLD_LO states) is compiled in with `define SWEEP_DWELL_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; count/dir keep their last values
// S_UP      | counting towards hi, dir=1
// S_DOWN    | counting towards lo, dir=0; lo here closes one sweep
// S_HOLD_HI | (dwell build) parked at hi for DWELL cycles, dir already 0
// S_HOLD_LO | (dwell build) parked at lo for DWELL cycles, dir already 1
module updown_sweep_ctrl #(
   parameter int W     = 4,
   parameter int DWELL = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         stop,
   input  logic [W-1:0] lo,
   input  logic [W-1:0] hi,
   input  logic [3:0]   cycles,
   output logic [W-1:0] count,
   output logic         dir,
   output logic         busy,
   output logic         done,
   output logic         err
);

`ifdef SWEEP_DWELL_EN
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_UP      = 3'd1,
      S_DOWN    = 3'd2,
      S_HOLD_HI = 3'd3,
      S_HOLD_LO = 3'd4
   } state_t;

   localparam int TW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [TW-1:0] TMR_LOAD = TW'(DWELL - 1);

   logic [TW-1:0] tmr_q, tmr_d;
`else
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_UP   = 2'd1,
      S_DOWN = 2'd2
   } state_t;
`endif

   generate
      if (DWELL < 1) begin : g_dwell_range
         $error("updown_sweep_ctrl: DWELL must be >= 1");
      end
   endgenerate

   state_t       state_q, state_d;
   logic [W-1:0] count_q, count_d;
   logic [W-1:0] lo_q, lo_d;
   logic [W-1:0] hi_q, hi_d;
   logic [3:0]   cyc_q, cyc_d;
   logic [3:0]   nsw_q, nsw_d;
   logic         dir_q, dir_d;
   logic         done_q, done_d;
   logic         err_q, err_d;
   logic         last_sweep;
   logic         flat;

   // cycles==0 never matches, which is what makes the program continuous
   assign last_sweep = (cyc_q != 4'd0) && ((nsw_q + 4'd1) == cyc_q);
   assign flat       = (hi_q == lo_q);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         lo_q    <= '0;
         hi_q    <= '0;
         cyc_q   <= '0;
         nsw_q   <= '0;
         dir_q   <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef SWEEP_DWELL_EN
         tmr_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         cyc_q   <= cyc_d;
         nsw_q   <= nsw_d;
         dir_q   <= dir_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef SWEEP_DWELL_EN
         tmr_q   <= tmr_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      cyc_d   = cyc_q;
      nsw_d   = nsw_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      err_d   = err_q;
`ifdef SWEEP_DWELL_EN
      tmr_d   = tmr_q;
`endif

      if (stop) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  if (lo > hi) begin
                     err_d = 1'b1;
                  end else begin
                     lo_d    = lo;
                     hi_d    = hi;
                     cyc_d   = cycles;
                     count_d = lo;
                     dir_d   = 1'b1;
                     nsw_d   = 4'd0;
                     err_d   = 1'b0;
                     state_d = S_UP;
                  end
               end
            end

            S_UP: begin
               if (count_q < hi_q) begin
                  count_d = count_q + 1'b1;
               end else begin
                  dir_d = 1'b0;
`ifdef SWEEP_DWELL_EN
                  tmr_d   = TMR_LOAD;
                  state_d = S_HOLD_HI;
`else
                  state_d = S_DOWN;
                  if (!flat) count_d = count_q - 1'b1;
`endif
               end
            end

            S_DOWN: begin
               if (count_q > lo_q) begin
                  count_d = count_q - 1'b1;
               end else if (last_sweep) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  nsw_d = nsw_q + 4'd1;
                  dir_d = 1'b1;
`ifdef SWEEP_DWELL_EN
                  tmr_d   = TMR_LOAD;
                  state_d = S_HOLD_LO;
`else
                  state_d = S_UP;
                  if (!flat) count_d = count_q + 1'b1;
`endif
               end
            end

`ifdef SWEEP_DWELL_EN
            // the exit cycle of a hold already performs the first step
            S_HOLD_HI: begin
               if (tmr_q == '0) begin
                  state_d = S_DOWN;
                  if (!flat) count_d = count_q - 1'b1;
               end else begin
                  tmr_d = tmr_q - 1'b1;
               end
            end

            S_HOLD_LO: begin
               if (tmr_q == '0) begin
                  state_d = S_UP;
                  if (!flat) count_d = count_q + 1'b1;
               end else begin
                  tmr_d = tmr_q - 1'b1;
               end
            end
`endif

            default: state_d = S_IDLE;
         endcase
      end
   end

   assign count = count_q;
   assign dir   = dir_q;
   assign busy  = (state_q != S_IDLE);
   assign done  = done_q;
   assign err   = err_q;

endmodule
